nrisc_ctrl_regfile: RTL and testbench

Control-and-register core of the 8-bit nRISC datapath: a two-phase control FSM that decodes the 3-bit opcode into datapath control signals, an 8×8-bit register file, and the branch-not-equal gate that drives the PC branch mux. It sits between the instruction memory/field extractors and the ALU/data memory. Register-index muxing, the ALU, the PC and the memories are outside this block.

---
 rtl/nrisc_ctrl_regfile.sv | 138 +++++++++++++
 tb/tb_nrisc_ctrl_regfile.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nrisc_ctrl_regfile.sv
// rtl/nrisc_ctrl_regfile.sv - nRISC two-phase control FSM, 8x8 register file and branch-not-equal gate
module nrisc_ctrl_regfile (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [2:0] reg1,
    input  logic [2:0] reg2,
    input  logic [2:0] regescr,
    input  logic [7:0] dadoescrito,
    input  logic       zero,
    output logic [7:0] dado1,
    output logic [7:0] dado2,
    output logic       pcesc,
    output logic       escreg,
    output logic       escmem,
    output logic       lermem,
    output logic [1:0] regdst,
    output logic [1:0] reglido1,
    output logic [1:0] reglido2,
    output logic       ulafonte1,
    output logic       ulafonte2,
    output logic [1:0] ulaop,
    output logic       regfonte,
    output logic       branchne,
    output logic       jump,
    output logic       sinaland
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_BNE  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] regs [0:7];

    // State register; reset always lands in FETCH regardless of current state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and enable decode; enables are live only in EXEC and are
    // forced low while reset is asserted so a pending write is discarded.
    always_comb begin
        state_d  = state_q;
        pcesc    = 1'b0;
        escreg   = 1'b0;
        escmem   = 1'b0;
        lermem   = 1'b0;
        branchne = 1'b0;
        jump     = 1'b0;
        case (state_q)
            FETCH: state_d = EXEC;
            EXEC: begin
                state_d = (opcode == OP_HALT) ? HALT : FETCH;
                if (!reset) begin
                    pcesc = (opcode != OP_HALT);
                    case (opcode)
                        OP_ADD, OP_SUB, OP_ADDI: escreg = 1'b1;
                        OP_LW: begin
                            escreg = 1'b1;
                            lermem = 1'b1;
                        end
                        OP_SW:   escmem   = 1'b1;
                        OP_BNE:  branchne = 1'b1;
                        OP_JMP:  jump     = 1'b1;
                        default: ;
                    endcase
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Datapath select decode, purely a function of opcode in every state.
    always_comb begin
        regdst    = 2'b00;
        reglido1  = 2'b00;
        reglido2  = 2'b00;
        ulafonte1 = 1'b0;
        ulafonte2 = 1'b0;
        ulaop     = 2'b00;
        regfonte  = 1'b0;
        case (opcode)
            OP_SUB:  ulaop = 2'b01;
            OP_ADDI: ulafonte2 = 1'b1;
            OP_LW: begin
                ulafonte1 = 1'b1;
                ulaop     = 2'b10;
                regfonte  = 1'b1;
            end
            OP_SW: begin
                ulafonte1 = 1'b1;
                ulaop     = 2'b10;
            end
            OP_BNE: begin
                reglido1 = 2'b01;
                reglido2 = 2'b10;
                ulaop    = 2'b01;
            end
            default: ;
        endcase
    end

    // Register file write port; reset clears every register and wins over a write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (escreg) begin
            regs[regescr] <= dadoescrito;
        end
    end

    // Read ports are asynchronous with no bypass; held at zero during reset.
    assign dado1 = reset ? 8'h00 : regs[reg1];
    assign dado2 = reset ? 8'h00 : regs[reg2];

    assign sinaland = branchne & ~zero;

endmodule

// File: tb/tb_nrisc_ctrl_regfile.sv
// tb/tb_nrisc_ctrl_regfile.sv - scoreboard bench for nrisc_ctrl_regfile
module tb_nrisc_ctrl_regfile;

    logic       clock;
    logic       reset;
    logic [2:0] opcode;
    logic [2:0] reg1;
    logic [2:0] reg2;
    logic [2:0] regescr;
    logic [7:0] dadoescrito;
    logic       zero;
    logic [7:0] dado1;
    logic [7:0] dado2;
    logic       pcesc;
    logic       escreg;
    logic       escmem;
    logic       lermem;
    logic [1:0] regdst;
    logic [1:0] reglido1;
    logic [1:0] reglido2;
    logic       ulafonte1;
    logic       ulafonte2;
    logic [1:0] ulaop;
    logic       regfonte;
    logic       branchne;
    logic       jump;
    logic       sinaland;

    nrisc_ctrl_regfile dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .reg1        (reg1),
        .reg2        (reg2),
        .regescr     (regescr),
        .dadoescrito (dadoescrito),
        .zero        (zero),
        .dado1       (dado1),
        .dado2       (dado2),
        .pcesc       (pcesc),
        .escreg      (escreg),
        .escmem      (escmem),
        .lermem      (lermem),
        .regdst      (regdst),
        .reglido1    (reglido1),
        .reglido2    (reglido2),
        .ulafonte1   (ulafonte1),
        .ulafonte2   (ulafonte2),
        .ulaop       (ulaop),
        .regfonte    (regfonte),
        .branchne    (branchne),
        .jump        (jump),
        .sinaland    (sinaland)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {dado1, dado2, pcesc, escreg, escmem, lermem, branchne, jump, sinaland,
    //  regdst, reglido1, reglido2, ulafonte1, ulafonte2, ulaop, regfonte}
    logic [33:0] obs;
    assign obs = {dado1, dado2, pcesc, escreg, escmem, lermem, branchne, jump, sinaland,
                  regdst, reglido1, reglido2, ulafonte1, ulafonte2, ulaop, regfonte};

    typedef struct {
        string       tag;
        logic [33:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    localparam int P_FETCH = 0;
    localparam int P_EXEC  = 1;
    localparam int P_HALT  = 2;

    int         m_phase = P_FETCH;
    logic [7:0] m_regs [0:7];

    task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {pcesc, escreg, escmem, lermem, branchne, jump}
    function automatic logic [5:0] ref_en(input logic [2:0] op);
        case (op)
            3'b000:  return 6'b110000;
            3'b001:  return 6'b110000;
            3'b010:  return 6'b110000;
            3'b011:  return 6'b110100;
            3'b100:  return 6'b101000;
            3'b101:  return 6'b100010;
            3'b110:  return 6'b100001;
            default: return 6'b000000;
        endcase
    endfunction

    // {regdst, reglido1, reglido2, ulafonte1, ulafonte2, ulaop, regfonte}
    function automatic logic [10:0] ref_sel(input logic [2:0] op);
        case (op)
            3'b001:  return 11'b00_00_00_0_0_01_0;
            3'b010:  return 11'b00_00_00_0_1_00_0;
            3'b011:  return 11'b00_00_00_1_0_10_1;
            3'b100:  return 11'b00_00_00_1_0_10_0;
            3'b101:  return 11'b00_01_10_0_0_01_0;
            default: return 11'b00_00_00_0_0_00_0;
        endcase
    endfunction

    // One clock cycle: drive inputs, push the model's expectation, sample
    // mid-cycle, then advance the model on the rising edge.
    task automatic step(input string tag, input logic rst, input logic [2:0] op,
                        input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] wi,
                        input logic [7:0] wd, input logic z);
        sb_item_t   it;
        sb_item_t   got_it;
        logic [5:0] en;
        logic [7:0] d1;
        logic [7:0] d2;
        reset       = rst;
        opcode      = op;
        reg1        = r1;
        reg2        = r2;
        regescr     = wi;
        dadoescrito = wd;
        zero        = z;
        en = (m_phase == P_EXEC && !rst) ? ref_en(op) : 6'b0;
        d1 = rst ? 8'h00 : m_regs[r1];
        d2 = rst ? 8'h00 : m_regs[r2];
        it.tag = tag;
        it.exp = {d1, d2, en, en[1] & ~z, ref_sel(op)};
        sb_q.push_back(it);
        #2;
        got_it = sb_q.pop_front();
        check_eq(got_it.tag, obs, got_it.exp);
        @(posedge clock);
        if (rst) begin
            m_phase = P_FETCH;
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        end else begin
            case (m_phase)
                P_FETCH: m_phase = P_EXEC;
                P_EXEC: begin
                    if (en[4]) m_regs[wi] = wd;
                    m_phase = (op == 3'b111) ? P_HALT : P_FETCH;
                end
                default: m_phase = P_HALT;
            endcase
        end
        @(negedge clock);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 3'b110, 3'd0, 3'd1, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic align_fetch();
        for (int k = 0; k < 3 && m_phase != P_FETCH; k++) idle("align");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        @(negedge clock);

        step("reset_a", 1'b1, 3'b000, 3'd3, 3'd4, 3'd3, 8'hAA, 1'b0);
        step("reset_b", 1'b1, 3'b101, 3'd1, 3'd2, 3'd1, 8'h11, 1'b0);

        for (int i = 0; i < 8; i++)
            step("idle_add", 1'b0, 3'b000, 3'(i), 3'(7 - i), 3'd0, 8'h00, 1'b0);

        align_fetch();
        step("add_fetch", 1'b0, 3'b000, 3'd3, 3'd0, 3'd3, 8'h5A, 1'b0);
        step("add_exec",  1'b0, 3'b000, 3'd3, 3'd0, 3'd3, 8'h5A, 1'b0);
        step("add_read",  1'b0, 3'b110, 3'd3, 3'd3, 3'd3, 8'h77, 1'b0);
        step("add_hold",  1'b0, 3'b110, 3'd3, 3'd0, 3'd3, 8'h77, 1'b0);

        align_fetch();
        step("r7_fetch", 1'b0, 3'b000, 3'd7, 3'd7, 3'd7, 8'hFF, 1'b0);
        step("r7_exec",  1'b0, 3'b000, 3'd7, 3'd7, 3'd7, 8'hFF, 1'b0);
        step("r7_read",  1'b0, 3'b000, 3'd7, 3'd7, 3'd7, 8'h33, 1'b0);
        step("r7_rst",   1'b1, 3'b000, 3'd7, 3'd7, 3'd7, 8'h33, 1'b0);
        step("r7_clear", 1'b0, 3'b110, 3'd7, 3'd7, 3'd0, 8'h00, 1'b0);

        align_fetch();
        step("bne_fetch_z0", 1'b0, 3'b101, 3'd0, 3'd1, 3'd0, 8'h00, 1'b0);
        step("bne_exec_z0",  1'b0, 3'b101, 3'd0, 3'd1, 3'd0, 8'h00, 1'b0);
        step("bne_fetch_z1", 1'b0, 3'b101, 3'd0, 3'd1, 3'd0, 8'h00, 1'b1);
        step("bne_exec_z1",  1'b0, 3'b101, 3'd0, 3'd1, 3'd0, 8'h00, 1'b1);

        align_fetch();
        step("lw_fetch", 1'b0, 3'b011, 3'd2, 3'd3, 3'd2, 8'hC3, 1'b0);
        step("lw_exec",  1'b0, 3'b011, 3'd2, 3'd3, 3'd2, 8'hC3, 1'b0);
        step("sw_fetch", 1'b0, 3'b100, 3'd2, 3'd3, 3'd4, 8'h99, 1'b0);
        step("sw_exec",  1'b0, 3'b100, 3'd2, 3'd4, 3'd4, 8'h99, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            if (m_phase == P_FETCH) op = 3'($urandom_range(0, 7));
            else                    op = 3'($urandom_range(0, 6));
            step("random", 1'b0, op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        align_fetch();
        step("halt_fetch", 1'b0, 3'b111, 3'd1, 3'd2, 3'd1, 8'h00, 1'b0);
        step("halt_exec",  1'b0, 3'b111, 3'd1, 3'd2, 3'd1, 8'h00, 1'b0);
        for (int n = 0; n < 12; n++)
            step("halt_hold", 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'b0);
        step("halt_rst",   1'b1, 3'b000, 3'd0, 3'd1, 3'd0, 8'h00, 1'b0);
        step("post_fetch", 1'b0, 3'b000, 3'd0, 3'd1, 3'd5, 8'h42, 1'b0);
        step("post_exec",  1'b0, 3'b000, 3'd5, 3'd1, 3'd5, 8'h42, 1'b0);
        step("post_read",  1'b0, 3'b110, 3'd5, 3'd0, 3'd0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
